// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, FSM encoding
// and the fetch credit rule shared by the issue logic.
package inst_fetch_unit_pkg;

  localparam int AWIDTH_DEF = 12;
  localparam int IWIDTH_DEF = 16;
  localparam int QDEPTH     = 2;

  // Instruction field positions: {opcode[15:12], rd[11:10], rs[9:8], imm[7:0]}
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // A new fetch may start only if every word already owed to decode (queued or
  // returning from the ROM), minus the one leaving this cycle, still leaves a slot.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue2.sv
// Two-entry FIFO holding {pc, instruction} pairs. The head is always slot0, so
// the output is driven straight from a register and stays stable while stalled.
module fetch_queue2 #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             do_pop;

  assign do_pop = pop & (count != 2'd0);
  assign head   = slot0;
  assign valid  = (count != 2'd0);

  // NOTE: the slots are reset as well as the count because the head drives the
  // inst/inst_pc outputs directly, and those must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let slot0 take the old slot1 while slot1
      // is overwritten in the same edge without any ordering dependence.
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, IDLE/RUN control, ROM issue with credit-based
// flow control, redirect/kill handling and a 2-deep registered output queue.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                AWIDTH   = AWIDTH_DEF,
  parameter int                IWIDTH   = IWIDTH_DEF,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [IWIDTH-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [IWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc
);

  fetch_state_e             state;
  logic [AWIDTH-1:0]        pc;
  logic [AWIDTH-1:0]        inflight_pc;
  logic                     inflight;
  logic                     issue;
  logic                     pop;
  logic                     push;
  logic                     kill;
  logic [1:0]               q_count;
  logic [AWIDTH+IWIDTH-1:0] q_head;

  assign pop  = inst_valid & inst_ready;

  // A redirect kills the word returning this cycle; nothing new was issued in
  // the redirect cycle, so no later word can belong to the old stream.
  assign kill = redirect_valid;
  assign push = inflight & ~kill;

  assign issue = (state == ST_RUN) & en_in & ~redirect_valid & ~rst
               & credit_ok(q_count, inflight, pop);

  assign rom_en   = issue;
  assign rom_addr = pc;

  assign inst_pc = q_head[AWIDTH+IWIDTH-1:IWIDTH];
  assign inst    = q_head[IWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: if (en_in)  state <= ST_RUN;
        ST_RUN:  if (!en_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      inflight <= issue;
      if (issue) inflight_pc <= pc;

      // Redirect outranks issue; pc wraps naturally at 2^AWIDTH.
      if (redirect_valid) pc <= redirect_pc;
      else if (issue)     pc <= pc + AWIDTH'(1);
    end
  end

  fetch_queue2 #(
    .WIDTH(AWIDTH + IWIDTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, rom_data}),
    .pop       (pop),
    .head      (q_head),
    .valid     (inst_valid),
    .count     (q_count)
  );

endmodule
